// File: rtl/serial_adder_seq.sv
// Bit-serial LSB-first adder: one sum bit per clock, registered carry forms the full adder.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input that computes a-b (cout=1 means no borrow).
module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             bit_out,
  output logic             bit_valid
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_a_q, shreg_a_d;
  logic [WIDTH-1:0] shreg_b_q, shreg_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  logic             load_sub;
  logic [WIDTH-1:0] b_load;
  logic             step_s;
  logic             step_c;
  logic             last_step;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

`ifdef SERIAL_ADD_SUB_EN
  assign load_sub = sub;
`else
  assign load_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
  assign b_load    = load_sub ? ~b : b;
  assign step_s    = shreg_a_q[0] ^ shreg_b_q[0] ^ carry_q;
  assign step_c    = maj3(shreg_a_q[0], shreg_b_q[0], carry_q);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_a_d   = shreg_a_q;
    shreg_b_d   = shreg_b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    bit_out_d   = bit_out_q;
    done_d      = 1'b0;
    bit_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_a_d = a;
          shreg_b_d = b_load;
          acc_d     = '0;
          carry_d   = load_sub;
          cnt_d     = '0;
        end
      end
      RUN: begin
        shreg_a_d   = shreg_a_q >> 1;
        shreg_b_d   = shreg_b_q >> 1;
        acc_d       = {step_s, acc_q[WIDTH-1:1]};
        carry_d     = step_c;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_out_d   = step_s;
        bit_valid_d = 1'b1;
        if (last_step) begin
          sum_d  = {step_s, acc_q[WIDTH-1:1]};
          cout_d = step_c;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_a_q   <= '0;
      shreg_b_q   <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      shreg_a_q   <= shreg_a_d;
      shreg_b_q   <= shreg_b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      done_q      <= done_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: vector table plus hand-written multi-cycle sequences.
// Sub vectors are exercised only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_seq;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         bit_out;
  logic         bit_valid;

  int checks = 0;
  int errors = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub_i),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[12];
  int   nvec;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; runs one full operation and one idle cycle after it.
  task automatic run_op(input vec_t v, input int idx);
    a = v.va; b = v.vb; sub_i = v.vsub; start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("v%0d_busy_after_accept", idx), 16'(busy), 16'd1);
    for (int k = 1; k <= W; k++) begin
      tick();
      check($sformatf("v%0d_bv%0d", idx, k), 16'(bit_valid), 16'd1);
      check($sformatf("v%0d_bit%0d", idx, k - 1), 16'(bit_out), 16'(v.es[k-1]));
      check($sformatf("v%0d_done%0d", idx, k), 16'(done), (k == W) ? 16'd1 : 16'd0);
      check($sformatf("v%0d_busy%0d", idx, k), 16'(busy), (k < W) ? 16'd1 : 16'd0);
    end
    check($sformatf("v%0d_sum", idx), 16'(sum), 16'(v.es));
    check($sformatf("v%0d_cout", idx), 16'(cout), 16'(v.ec));
    tick();
    check($sformatf("v%0d_done_drop", idx), 16'(done), 16'd0);
    check($sformatf("v%0d_bv_drop", idx), 16'(bit_valid), 16'd0);
    check($sformatf("v%0d_sum_hold", idx), 16'(sum), 16'(v.es));
  endtask

  initial begin
    vec_t v;
    logic early;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    nvec = 7;
`ifdef SERIAL_ADD_SUB_EN
    vecs[7] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
    vecs[8] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
    vecs[9] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1};
    nvec = 10;
`endif

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_sum", 16'(sum), 16'd0);
    check("rst_cout", 16'(cout), 16'd0);
    check("rst_bit_out", 16'(bit_out), 16'd0);
    check("rst_bit_valid", 16'(bit_valid), 16'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 16'(busy), 16'd0);

    for (int i = 0; i < nvec; i++) run_op(vecs[i], i);

    // Start pulse during RUN must be ignored.
    a = 8'h01; b = 8'h02; sub_i = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (k == 2) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
      if (k == 3) start = 1'b0;
      tick();
      if (k < W && done) early = 1'b1;
    end
    check("ign_no_early_done", 16'(early), 16'd0);
    check("ign_done", 16'(done), 16'd1);
    check("ign_sum", 16'(sum), 16'h03);
    check("ign_cout", 16'(cout), 16'd0);
    tick();
    check("ign_not_queued", 16'(busy), 16'd0);

    // Held start: back-to-back accept in the done cycle.
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    early = 1'b0;
    for (int k = 1; k <= W; k++) begin
      tick();
      if (k < W && done) early = 1'b1;
    end
    check("held_no_early_done", 16'(early), 16'd0);
    check("held_done1", 16'(done), 16'd1);
    check("held_sum1", 16'(sum), 16'h30);
    a = 8'h01; b = 8'h01;
    tick();
    start = 1'b0;
    check("held_reaccept_busy", 16'(busy), 16'd1);
    check("held_reaccept_done", 16'(done), 16'd0);
    early = 1'b0;
    for (int k = 1; k <= W; k++) begin
      tick();
      if (k < W && done) early = 1'b1;
    end
    check("held_no_early_done2", 16'(early), 16'd0);
    check("held_done2", 16'(done), 16'd1);
    check("held_sum2", 16'(sum), 16'h02);
    check("held_cout2", 16'(cout), 16'd0);
    tick();

    // Asynchronous reset in the middle of an operation.
    a = 8'h0F; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_bit_valid", 16'(bit_valid), 16'd0);
    check("mid_rst_sum", 16'(sum), 16'd0);
    check("mid_rst_done", 16'(done), 16'd0);
    check("mid_rst_bit_out", 16'(bit_out), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy || bit_valid) early = 1'b1;
    end
    check("mid_rst_no_done", 16'(early), 16'd0);
    v = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    run_op(v, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial multi-bit adder: one sum bit per clock, LSB first. Each step is the XOR/AND half-adder pair plus a registered carry, which makes a full adder.
- Accepts two WIDTH-bit operands on a start pulse and returns the WIDTH-bit sum and carry-out with a done pulse.
- Also streams each sum bit as it is produced, so a downstream stage can consume results serially.
- Sits between the ui_in operand pins and the uo_out result pins of the tile top level.

Parameters:
- WIDTH, 8, operand and result width in bits (2..16).
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  result register; holds its value until the next completion.
- cout  output  1  final carry; holds its value until the next completion.
- bit_out  output  1  sum bit produced this step.
- bit_valid  output  1  qualifies bit_out; high for exactly WIDTH cycles per operation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, cout, bit_out, bit_valid all 0; carry, counter and shift registers cleared.
- Reset mid-operation: the in-flight operation is discarded with no done pulse; the block is in IDLE on the first edge after release.
- States: IDLE and RUN.
- IDLE, start=1 at edge E0:
  - load shreg_a=a and shreg_b=b;
  - carry=0 (1 for subtract, see Optional Feature);
  - cnt=0;
  - go to RUN; busy=1 after E0.
- IDLE, start=0: hold; done and bit_valid are 0 after the edge.
- RUN, each edge:
  - s = shreg_a[0] ^ shreg_b[0] ^ carry;
  - carry <= majority(shreg_a[0], shreg_b[0], carry);
  - shift shreg_a and shreg_b right by 1;
  - shift s into the accumulator at its MSB;
  - bit_out <= s; bit_valid <= 1; cnt <= cnt+1.
- RUN, edge with cnt==WIDTH-1 (edge E0+WIDTH):
  - final step as above;
  - sum <= completed accumulator; cout <= final carry;
  - done <= 1; busy <= 0; go to IDLE.
- Latency: start accepted at E0 gives bit_valid high after edges E0+1 .. E0+WIDTH, and done high for the single cycle after E0+WIDTH.
- The bit_out sequence is sum[0] first, sum[WIDTH-1] last.
- start while busy=1 is ignored, with no queueing; a and b may change freely during RUN.
- start high in the done cycle is accepted (state is IDLE), allowing back-to-back operations with zero idle cycles.
- A held-high start re-triggers on every completion.
- sum and cout change only on a completion edge or on reset.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a+b.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - adds input port sub (1 bit), captured with the operands at start;
  - sub=1 computes a-b: shreg_b is loaded with ~b and the initial carry is 1;
  - cout=1 means no borrow (a>=b unsigned); sub=0 behaves as the plain adder.
- Undefined: no sub port; add only, initial carry always 0.

Test Plan:
- Reset, then start with a=8'h5A, b=8'h3C:
  - busy high for 8 cycles, then done pulse, sum=8'h96, cout=0;
  - bit_out sequence LSB-first 0,1,1,0,1,0,0,1, with bit_valid high for 8 cycles.
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1. Then a=8'h00, b=8'h00 → sum=8'h00, cout=0.
- Start a=8'h01, b=8'h02; pulse start again with a=8'hFF, b=8'hFF at cycle 3 of RUN:
  - the second start is ignored;
  - done occurs exactly 8 cycles after the first accept, with sum=8'h03, cout=0.
- Hold start high with a=8'h10, b=8'h20, then change operands to a=8'h01, b=8'h01 in the done cycle:
  - first done gives sum=8'h30;
  - next accept is in the same cycle as done, and the second done comes 8 cycles later with sum=8'h02.
- Assert rst_n=0 at RUN cycle 4 (a=8'h0F, b=8'h0F):
  - outputs go to 0 immediately and no done pulse follows;
  - a new start after release with a=8'h03, b=8'h04 gives sum=8'h07.
- With SERIAL_ADD_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 → sum=8'h0F, cout=1;
  - sub=1, a=8'h00, b=8'h01 → sum=8'hFF, cout=0.
